// File: rtl/uart_hex_send.sv
// rtl/uart_hex_send.sv - UART 8N1 transmitter printing a 32-bit word as 8 uppercase hex chars
// Optional CR/LF trailer; start is accepted only while idle.
module uart_hex_send #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BAUD        = 9600,
  parameter int APPEND_CRLF = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] data,
  output logic        dout,
  output logic        busy,
  output logic        done
);

  localparam int BIT_CYC = CLK_FREQ / BAUD;
  localparam int CW      = $clog2(BIT_CYC);
  localparam int N_CHR   = 8 + 2 * APPEND_CRLF;

  localparam logic [CW-1:0] CNT_MAX  = CW'(BIT_CYC - 1);
  localparam logic [3:0]    LAST_CHR = 4'(N_CHR - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    r_state;
  logic [31:0]   r_word;
  logic [3:0]    r_char_idx;
  logic [2:0]    r_bit_idx;
  logic [CW-1:0] r_cnt;
  logic          r_dout;
  logic          r_busy;
  logic          r_done;

  logic [3:0] w_nib;
  logic [7:0] w_char;
  logic       w_cnt_end;

  // Char 0 is the top nibble: shift amount is 4*(7-idx).
  always_comb begin
    w_nib = 4'(r_word >> {~r_char_idx[2:0], 2'b00});
    if (r_char_idx == 4'd8)
      w_char = 8'h0D;
    else if (r_char_idx == 4'd9)
      w_char = 8'h0A;
    else if (w_nib < 4'd10)
      w_char = 8'h30 + {4'h0, w_nib};
    else
      w_char = 8'h37 + {4'h0, w_nib};
  end

  assign w_cnt_end = (r_cnt == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_word     <= 32'h0;
      r_char_idx <= 4'd0;
      r_bit_idx  <= 3'd0;
      r_cnt      <= '0;
      r_dout     <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_word     <= data;
            r_char_idx <= 4'd0;
            r_bit_idx  <= 3'd0;
            r_cnt      <= '0;
            r_state    <= S_START;
            r_dout     <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_START: begin
          if (w_cnt_end) begin
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_state   <= S_DATA;
            r_dout    <= w_char[0];
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_cnt_end) begin
            r_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
              r_dout  <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_dout    <= w_char[r_bit_idx + 3'd1];
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_cnt_end) begin
            r_cnt <= '0;
            // Next char starts with no idle gap; only the frame end returns to idle.
            if (r_char_idx == LAST_CHR) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_char_idx <= r_char_idx + 4'd1;
              r_state    <= S_START;
              r_dout     <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dout = r_dout;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_uart_hex_send.sv
// tb/tb_uart_hex_send.sv - directed self-checking bench for uart_hex_send
// dut_a: BIT_CYC=16 with CR/LF; dut_b: BIT_CYC=16 without CR/LF.
module tb_uart_hex_send;

  localparam int BC = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic [31:0] data_a, data_b;
  logic        dout_a, busy_a, done_a;
  logic        dout_b, busy_b, done_b;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int done_cnt_a = 0, done_cyc_a = 0;
  int done_cnt_b = 0, done_cyc_b = 0;

  uart_hex_send #(.CLK_FREQ(16), .BAUD(1), .APPEND_CRLF(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .data(data_a),
    .dout(dout_a), .busy(busy_a), .done(done_a)
  );

  uart_hex_send #(.CLK_FREQ(16), .BAUD(1), .APPEND_CRLF(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .data(data_b),
    .dout(dout_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (done_a === 1'b1) begin
      done_cnt_a = done_cnt_a + 1;
      done_cyc_a = cyc;
    end
    if (done_b === 1'b1) begin
      done_cnt_b = done_cnt_b + 1;
      done_cyc_b = cyc;
    end
  end

  function automatic logic line(input bit sel);
    return sel ? dout_b : dout_a;
  endfunction

  // Returns at the negedge just after the accepting edge.
  task automatic send(input bit sel, input logic [31:0] d);
    @(negedge clk);
    if (sel) begin start_b = 1'b1; data_b = d; end
    else     begin start_a = 1'b1; data_a = d; end
    @(negedge clk);
    if (sel) start_b = 1'b0; else start_a = 1'b0;
    acc_cyc = cyc;
  endtask

  // Samples each bit mid-cell; a timeout or bad stop bit yields an X byte.
  task automatic rx_char(input bit sel, output logic [7:0] b);
    int n;
    n = 0;
    b = 8'h00;
    while (line(sel) !== 1'b0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) begin
      b = 8'hxx;
      return;
    end
    repeat (BC / 2) @(negedge clk);
    if (line(sel) !== 1'b0) b = 8'hxx;
    for (int i = 0; i < 8; i++) begin
      repeat (BC) @(negedge clk);
      b[i] = line(sel);
    end
    repeat (BC) @(negedge clk);
    if (line(sel) !== 1'b1) b = 8'hxx;
  endtask

  task automatic wait_done(input bit sel, input int base);
    int n;
    n = 0;
    while ((sel ? done_cnt_b : done_cnt_a) == base && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; data_a = '0; data_b = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({dout_a, busy_a, done_a} !== 3'b100) begin
      n_bad++;
      $display("FAIL reset_a: dout/busy/done=%b expected 100", {dout_a, busy_a, done_a});
    end
    n_cmp++;
    if ({dout_b, busy_b, done_b} !== 3'b100) begin
      n_bad++;
      $display("FAIL reset_b: dout/busy/done=%b expected 100", {dout_b, busy_b, done_b});
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_crlf_frame;
    logic [7:0] exp [10] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
    logic [7:0] b;
    int base;
    base = done_cnt_a;
    send(0, 32'h1234ABCD);
    n_cmp++;
    if ({dout_a, busy_a} !== 2'b01) begin
      n_bad++;
      $display("FAIL accept_latency: dout/busy=%b expected 01", {dout_a, busy_a});
    end
    for (int i = 0; i < 10; i++) begin
      rx_char(0, b);
      n_cmp++;
      if (b !== exp[i]) begin
        n_bad++;
        $display("FAIL crlf_char%0d: got %h expected %h", i, b, exp[i]);
      end
    end
    wait_done(0, base);
    n_cmp++;
    if (done_cyc_a - acc_cyc !== 1600) begin
      n_bad++;
      $display("FAIL crlf_done_time: got %0d expected 1600", done_cyc_a - acc_cyc);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (done_cnt_a !== base + 1 || busy_a !== 1'b0) begin
      n_bad++;
      $display("FAIL crlf_done_once: dones=%0d busy=%b expected %0d 0", done_cnt_a - base, busy_a, 1);
    end
  endtask

  task automatic test_no_crlf;
    logic [7:0] b;
    int base;
    base = done_cnt_b;
    send(1, 32'h00000000);
    for (int i = 0; i < 8; i++) begin
      rx_char(1, b);
      n_cmp++;
      if (b !== 8'h30) begin
        n_bad++;
        $display("FAIL zero_char%0d: got %h expected 30", i, b);
      end
    end
    wait_done(1, base);
    n_cmp++;
    if (done_cyc_b - acc_cyc !== 1280) begin
      n_bad++;
      $display("FAIL zero_done_time: got %0d expected 1280", done_cyc_b - acc_cyc);
    end
    send(1, 32'hFFFFFFFF);
    for (int i = 0; i < 8; i++) begin
      rx_char(1, b);
      n_cmp++;
      if (b !== 8'h46) begin
        n_bad++;
        $display("FAIL ones_char%0d: got %h expected 46", i, b);
      end
    end
    wait_done(1, done_cnt_b);
  endtask

  task automatic test_ignore_busy;
    logic [7:0] exp [8] = '{8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
    logic [7:0] got [8];
    logic [7:0] b;
    int base;
    repeat (4) @(negedge clk);
    base = done_cnt_b;
    send(1, 32'h89ABCDEF);
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          rx_char(1, b);
          got[i] = b;
        end
      end
      begin
        repeat (499) @(negedge clk);
        start_b = 1'b1; data_b = 32'h00000000;
        @(negedge clk);
        start_b = 1'b0;
        n_cmp++;
        if (busy_b !== 1'b1) begin
          n_bad++;
          $display("FAIL busy_during_ignore: got %b expected 1", busy_b);
        end
      end
    join
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (got[i] !== exp[i]) begin
        n_bad++;
        $display("FAIL busy_char%0d: got %h expected %h", i, got[i], exp[i]);
      end
    end
    wait_done(1, base);
    n_cmp++;
    if (done_cyc_b - acc_cyc !== 1280) begin
      n_bad++;
      $display("FAIL busy_done_time: got %0d expected 1280", done_cyc_b - acc_cyc);
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (busy_b !== 1'b0 || dout_b !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_no_relaunch: busy/dout=%b%b expected 01", busy_b, dout_b);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] b;
    int base;
    repeat (4) @(negedge clk);
    base = done_cnt_b;
    send(1, 32'h12345678);
    // Char 2 data bits occupy 336..463 clocks after the accepting edge.
    repeat (370) @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({dout_b, busy_b, done_b} !== 3'b100) begin
      n_bad++;
      $display("FAIL midreset_out: dout/busy/done=%b expected 100", {dout_b, busy_b, done_b});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (done_cnt_b !== base || busy_b !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_nodone: dones=%0d busy=%b expected 0 0", done_cnt_b - base, busy_b);
    end
    send(1, 32'h0000000F);
    for (int i = 0; i < 8; i++) begin
      rx_char(1, b);
      n_cmp++;
      if (b !== ((i == 7) ? 8'h46 : 8'h30)) begin
        n_bad++;
        $display("FAIL postreset_char%0d: got %h expected %h", i, b, (i == 7) ? 8'h46 : 8'h30);
      end
    end
    wait_done(1, base);
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp [10] = '{8'h41, 8'h35, 8'h41, 8'h35, 8'h41, 8'h35, 8'h41, 8'h35, 8'h0D, 8'h0A};
    logic [7:0] got [10];
    logic [7:0] b;
    int base, t1, t2, n;
    repeat (4) @(negedge clk);
    base = done_cnt_a;
    t1 = 0; t2 = 0;
    start_a = 1'b1; data_a = 32'hA5A5A5A5;
    @(negedge clk);
    acc_cyc = cyc;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          rx_char(0, b);
          got[i] = b;
        end
      end
      begin
        n = 0;
        while (done_a !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
        t1 = cyc;
        n_cmp++;
        if ({dout_a, busy_a} !== 2'b10) begin
          n_bad++;
          $display("FAIL b2b_gap_idle: dout/busy=%b expected 10", {dout_a, busy_a});
        end
        @(negedge clk);
        n_cmp++;
        if ({dout_a, busy_a} !== 2'b01) begin
          n_bad++;
          $display("FAIL b2b_restart: dout/busy=%b expected 01", {dout_a, busy_a});
        end
        n = 0;
        while (done_a !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
        t2 = cyc;
        start_a = 1'b0;
      end
    join
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (got[i] !== exp[i]) begin
        n_bad++;
        $display("FAIL b2b_char%0d: got %h expected %h", i, got[i], exp[i]);
      end
    end
    n_cmp++;
    if (t1 - acc_cyc !== 1600 || t2 - t1 !== 1601) begin
      n_bad++;
      $display("FAIL b2b_period: first=%0d spacing=%0d expected 1600 1601", t1 - acc_cyc, t2 - t1);
    end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (done_cnt_a !== base + 2 || busy_a !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_done_count: dones=%0d busy=%b expected 2 0", done_cnt_a - base, busy_a);
    end
  endtask

  initial begin
    test_reset;
    test_crlf_frame;
    test_no_crlf;
    test_ignore_busy;
    test_reset_mid;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
